// File: rtl/word_fetch16.sv
// word_fetch16: reads two consecutive bytes over a req/ack handshake,
// assembles them into a 16-bit word and presents it with a one-cycle
// valid strobe. A bounded wait per byte aborts stalled fetches with an
// error pulse.
//
// Parameters:
//   LITTLE_ENDIAN 1: byte at addr -> word_out_o[7:0]; 0: -> word_out_o[15:8]
//   TIMEOUT       max cycles waited for mem_ack_i per byte; 0 disables
// Ports:
//   clk_i         clock, rising edge
//   res_ni        synchronous active-low reset
//   start_i       request a fetch (accepted when not fetching)
//   addr_i        byte address of first byte, latched on accept
//   busy_o        high in every state except IDLE
//   mem_req_o     memory read request
//   mem_addr_o    byte address of current request
//   mem_ack_i     memory completes current byte this cycle
//   mem_data_i    read byte, valid with mem_ack_i
//   word_out_o    assembled word, holds until next successful fetch
//   word_valid_o  one-cycle pulse, word_out_o newly valid
//   err_o         one-cycle pulse, fetch aborted by timeout
module word_fetch16 #(
  parameter bit          LITTLE_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic        clk_i,
  input  logic        res_ni,
  input  logic        start_i,
  input  logic [15:0] addr_i,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [15:0] word_out_o,
  output logic        word_valid_o,
  output logic        err_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [7:0]         first_q, first_d;
  logic [15:0]        word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_d;
  logic               busy_q, mem_req_q, word_valid_q, err_q;
  logic               timeout_hit;

  // A pending ack always wins over the timeout in the same cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT)) && !mem_ack_i;

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    first_d    = first_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;

    unique case (state_q)
      // DONE hands back to IDLE on the same edge, so a start seen there is
      // accepted exactly as IDLE would; this gives 1 word per 3 cycles.
      IDLE, DONE: begin
        if (start_i) begin
          mem_addr_d = addr_i;
          cnt_d      = '0;
          state_d    = RD_LO;
        end else begin
          state_d    = IDLE;
        end
      end
      RD_LO: begin
        if (mem_ack_i) begin
          first_d    = mem_data_i;
          mem_addr_d = mem_addr_q + 16'd1;
          cnt_d      = '0;
          state_d    = RD_HI;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_HI: begin
        if (mem_ack_i) begin
          word_d  = LITTLE_ENDIAN ? {mem_data_i, first_q} : {first_q, mem_data_i};
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i) begin
    if (!res_ni) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      first_q      <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      first_q      <= first_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      busy_q       <= (state_d != IDLE);
      mem_req_q    <= (state_d == RD_LO) || (state_d == RD_HI);
      word_valid_q <= (state_d == DONE);
      err_q        <= err_d;
    end
  end

  assign busy_o       = busy_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign word_out_o   = word_q;
  assign word_valid_o = word_valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_word_fetch16.sv
// Directed bench for word_fetch16: one little-endian and one big-endian
// instance (both TIMEOUT=4) share all inputs and are checked side by side.
module tb_word_fetch16;

  logic        clk = 1'b0;
  logic        res_n;
  logic        start;
  logic [15:0] addr;
  logic        ack;
  logic [7:0]  data;

  logic        le_busy, le_req, le_wv, le_err;
  logic        be_busy, be_req, be_wv, be_err;
  logic [15:0] le_addr, be_addr, le_word, be_word;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_le = 16'h0;
  logic [15:0] exp_be = 16'h0;

  // busy, mem_req, word_valid, err for each instance
  wire [7:0]  ctl   = {le_busy, le_req, le_wv, le_err, be_busy, be_req, be_wv, be_err};
  wire [31:0] maddr = {le_addr, be_addr};
  wire [31:0] words = {le_word, be_word};

  always #5 clk = ~clk;

  word_fetch16 #(.LITTLE_ENDIAN(1'b1), .TIMEOUT(4)) u_le (
    .clk_i(clk), .res_ni(res_n), .start_i(start), .addr_i(addr),
    .busy_o(le_busy), .mem_req_o(le_req), .mem_addr_o(le_addr),
    .mem_ack_i(ack), .mem_data_i(data), .word_out_o(le_word),
    .word_valid_o(le_wv), .err_o(le_err)
  );

  word_fetch16 #(.LITTLE_ENDIAN(1'b0), .TIMEOUT(4)) u_be (
    .clk_i(clk), .res_ni(res_n), .start_i(start), .addr_i(addr),
    .busy_o(be_busy), .mem_req_o(be_req), .mem_addr_o(be_addr),
    .mem_ack_i(ack), .mem_data_i(data), .word_out_o(be_word),
    .word_valid_o(be_wv), .err_o(be_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    res_n = 1'b0; start = 1'b1; addr = 16'h1234; ack = 1'b1; data = 8'hAA;
    step(); step();
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%h want=%h", ctl, 8'h00); end
    total++; if (maddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=%h", maddr, 32'h0); end
    total++; if (words !== 32'h0) begin bad++; $display("FAIL reset_word got=%h want=%h", words, 32'h0); end
    res_n = 1'b1; start = 1'b0; ack = 1'b0;
    step();
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_idle got=%h want=%h", ctl, 8'h00); end
  endtask

  // Fetch 0x34 @0x0040, 0x12 @0x0041 with immediate acks.
  task automatic test_basic(input string tag);
    start = 1'b1; addr = 16'h0040;
    step();
    total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL %s_lo_ctl got=%h want=%h", tag, ctl, 8'hCC); end
    total++; if (maddr !== 32'h0040_0040) begin bad++; $display("FAIL %s_lo_addr got=%h want=%h", tag, maddr, 32'h0040_0040); end
    start = 1'b0; ack = 1'b1; data = 8'h34;
    step();
    total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL %s_hi_ctl got=%h want=%h", tag, ctl, 8'hCC); end
    total++; if (maddr !== 32'h0041_0041) begin bad++; $display("FAIL %s_hi_addr got=%h want=%h", tag, maddr, 32'h0041_0041); end
    total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL %s_partial got=%h want=%h", tag, words, {exp_le, exp_be}); end
    data = 8'h12;
    step();
    exp_le = 16'h1234; exp_be = 16'h3412;
    total++; if (ctl !== 8'hAA) begin bad++; $display("FAIL %s_done_ctl got=%h want=%h", tag, ctl, 8'hAA); end
    total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL %s_word got=%h want=%h", tag, words, {exp_le, exp_be}); end
    ack = 1'b0;
    step();
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL %s_after_ctl got=%h want=%h", tag, ctl, 8'h00); end
    total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL %s_hold got=%h want=%h", tag, words, {exp_le, exp_be}); end
  endtask

  // addr 0xFFFF wraps to 0x0000; two wait cycles per byte; stray starts.
  task automatic test_wrap();
    start = 1'b1; addr = 16'hFFFF;
    step();
    total++; if (maddr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_lo_addr got=%h want=%h", maddr, 32'hFFFF_FFFF); end
    addr = 16'h1111;
    step();
    start = 1'b0;
    step();
    total++; if (maddr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_stray_addr got=%h want=%h", maddr, 32'hFFFF_FFFF); end
    ack = 1'b1; data = 8'hCD;
    step();
    total++; if (maddr !== 32'h0) begin bad++; $display("FAIL wrap_hi_addr got=%h want=%h", maddr, 32'h0); end
    total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL wrap_hi_ctl got=%h want=%h", ctl, 8'hCC); end
    ack = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL wrap_wait_ctl got=%h want=%h", ctl, 8'hCC); end
    ack = 1'b1; data = 8'hAB;
    step();
    exp_le = 16'hABCD; exp_be = 16'hCDAB;
    total++; if (ctl !== 8'hAA) begin bad++; $display("FAIL wrap_done_ctl got=%h want=%h", ctl, 8'hAA); end
    total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL wrap_word got=%h want=%h", words, {exp_le, exp_be}); end
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (ctl !== 8'h00) begin bad++; $display("FAIL wrap_no_extra[%0d] got=%h want=%h", i, ctl, 8'h00); end
    end
  endtask

  // No hi ack: err 5 cycles after RD_HI entry; or ack exactly at the limit.
  task automatic test_timeout(input bit late_ack);
    start = 1'b1; addr = 16'h0200;
    step();
    start = 1'b0; ack = 1'b1; data = 8'h77;
    step();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL to%0d_wait[%0d] got=%h want=%h", late_ack, i, ctl, 8'hCC); end
      step();
    end
    if (late_ack) begin
      ack = 1'b1; data = 8'h66;
      step();
      exp_le = 16'h6677; exp_be = 16'h7766;
      total++; if (ctl !== 8'hAA) begin bad++; $display("FAIL to_late_ctl got=%h want=%h", ctl, 8'hAA); end
      total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL to_late_word got=%h want=%h", words, {exp_le, exp_be}); end
      ack = 1'b0;
      step();
      total++; if (ctl !== 8'h00) begin bad++; $display("FAIL to_late_after got=%h want=%h", ctl, 8'h00); end
    end else begin
      total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL to_last_wait got=%h want=%h", ctl, 8'hCC); end
      step();
      total++; if (ctl !== 8'h11) begin bad++; $display("FAIL to_err_ctl got=%h want=%h", ctl, 8'h11); end
      total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL to_word_kept got=%h want=%h", words, {exp_le, exp_be}); end
      step();
      total++; if (ctl !== 8'h00) begin bad++; $display("FAIL to_err_pulse got=%h want=%h", ctl, 8'h00); end
    end
  endtask

  // start held through DONE launches the next fetch immediately.
  task automatic test_back_to_back();
    start = 1'b1; addr = 16'h0010;
    step();
    start = 1'b0; ack = 1'b1; data = 8'h01;
    step();
    data = 8'h02;
    step();
    exp_le = 16'h0201; exp_be = 16'h0102;
    total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL b2b_w1 got=%h want=%h", words, {exp_le, exp_be}); end
    start = 1'b1; addr = 16'h0020; ack = 1'b0;
    step();
    total++; if (ctl !== 8'hCC) begin bad++; $display("FAIL b2b_lo_ctl got=%h want=%h", ctl, 8'hCC); end
    total++; if (maddr !== 32'h0020_0020) begin bad++; $display("FAIL b2b_lo_addr got=%h want=%h", maddr, 32'h0020_0020); end
    start = 1'b0; ack = 1'b1; data = 8'h03;
    step();
    data = 8'h04;
    step();
    exp_le = 16'h0403; exp_be = 16'h0304;
    total++; if (ctl !== 8'hAA) begin bad++; $display("FAIL b2b_done_ctl got=%h want=%h", ctl, 8'hAA); end
    total++; if (words !== {exp_le, exp_be}) begin bad++; $display("FAIL b2b_w2 got=%h want=%h", words, {exp_le, exp_be}); end
    ack = 1'b0;
    step();
  endtask

  // Reset asserted in RD_HI alongside an ack.
  task automatic test_mid_reset();
    start = 1'b1; addr = 16'h0300;
    step();
    start = 1'b0; ack = 1'b1; data = 8'h99;
    step();
    res_n = 1'b0; data = 8'h88;
    step();
    exp_le = 16'h0; exp_be = 16'h0;
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL mrst_ctl got=%h want=%h", ctl, 8'h00); end
    total++; if (words !== 32'h0) begin bad++; $display("FAIL mrst_word got=%h want=%h", words, 32'h0); end
    total++; if (maddr !== 32'h0) begin bad++; $display("FAIL mrst_addr got=%h want=%h", maddr, 32'h0); end
    res_n = 1'b1; ack = 1'b0;
    step();
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL mrst_idle got=%h want=%h", ctl, 8'h00); end
  endtask

  initial begin
    res_n = 1'b0; start = 1'b0; addr = '0; ack = 1'b0; data = '0;
    step();
    test_reset();
    test_basic("basic");
    test_wrap();
    test_basic("refill");
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_mid_reset();
    test_basic("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_fetch16.md
# word_fetch16

Byte-to-word fetch sequencer that sits directly upstream of the 16-bit register. It reads two consecutive bytes from byte-wide memory over a req/ack handshake and assembles them into a 16-bit word. It then presents that word with a one-cycle valid strobe, so the register can capture it on its D input. A bounded wait on each byte aborts stalled fetches with an error pulse.

## Interface
- LITTLE_ENDIAN, 1, 1: byte at addr → word_out[7:0]; 0: byte at addr → word_out[15:8]
- TIMEOUT, 15, max cycles waited for mem_ack per byte; 0 disables timeout
- CLK  in  1  clock; all state changes on rising edge
- RES  in  1  reset, synchronous, active-low
- start  in  1  request a word fetch; sampled only in IDLE
- addr  in  16  byte address of first byte; latched when start accepted
- busy  out  1  high in every state except IDLE
- mem_req  out  1  memory read request
- mem_addr  out  16  byte address for current request
- mem_ack  in  1  memory completes current byte this cycle
- mem_data  in  8  read byte; valid when mem_ack=1
- word_out  out  16  assembled word; holds value until next successful fetch
- word_valid  out  1  one-cycle pulse, word_out newly valid
- err  out  1  one-cycle pulse, fetch aborted by timeout

## Operation
- States: IDLE, RD_LO (first byte), RD_HI (second byte), DONE.
- IDLE: busy=0, mem_req=0. start=1 → latch addr, mem_addr<=addr, → RD_LO.
- RD_LO: mem_req=1. mem_ack=1 → capture mem_data into first-byte lane, mem_addr<=mem_addr+1, → RD_HI.
- Address increment is mod 2^16: 0xFFFF → 0x0000.
- RD_HI: mem_req=1. mem_ack=1 → capture mem_data into second-byte lane, → DONE.
- DONE: word_out<=assembled word, word_valid=1, mem_req=0, → IDLE.
- word_out updates only on DONE entry. Partial bytes are never visible on word_out.
- start outside IDLE is ignored; no queuing.
- mem_ack outside RD_LO/RD_HI is ignored.
- Timeout: wait counter clears on entry to RD_LO and RD_HI. It increments each cycle in those states with mem_ack=0.
- When the counter equals TIMEOUT with mem_ack=0 in the same cycle → err=1 next cycle, mem_req=0, → IDLE. word_out is unchanged.
- mem_ack arriving in the cycle the counter reaches TIMEOUT wins: the byte is accepted and there is no err.
- Reset (RES=0 at edge): → IDLE; mem_req, busy, word_valid, err = 0; mem_addr, word_out, byte latches = 0.
- Reset applies from any state, including mid-fetch. mem_ack in the reset cycle is ignored.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- start sampled at edge n → busy and mem_req high from cycle n+1.
- Best case: ack in cycle n+1 (lo) and n+2 (hi) → word_valid high in cycle n+3. Minimum latency is 3 cycles.
- Back-to-back: the next start can be accepted at the edge ending the DONE cycle. Peak throughput is 1 word per 3 cycles.
- mem_req stays high continuously across RD_LO→RD_HI. mem_addr changes at the edge that accepts the lo ack.
- An ack in the first RD_HI cycle is legal and completes the hi byte.
- word_valid and err are never high together, and each is high for exactly one cycle per fetch.

## Test plan
- Reset: hold RES=0 for 2 cycles with start=1 → all outputs 0, busy=0, no mem_req.
- Basic fetch, LITTLE_ENDIAN=1: start, addr=0x0040; mem_data 0x34 then 0x12, immediate acks → mem_addr 0x0040 then 0x0041, word_out=0x1234, word_valid at cycle n+3.
- Same fetch with LITTLE_ENDIAN=0 → word_out=0x3412.
- Wrap and wait states: addr=0xFFFF, 2-cycle delayed acks → mem_addr 0xFFFF then 0x0000, word_out correct; start pulses while busy produce no extra fetches.
- Timeout, TIMEOUT=4: no ack on hi byte → err pulse 5 cycles after RD_HI entry, mem_req drops, word_out keeps previous 0x1234. Repeat with ack on 4th idle cycle → success, no err.
- Mid-fetch reset: RES=0 during RD_HI → next cycle IDLE, word_out=0, no word_valid. A subsequent normal fetch succeeds.
